// File: rtl/pq_arbiter.sv
// pq_pkg + pq_arbiter: round-robin front end that lets N_CLIENTS requesters
// share a single priority queue. One request is outstanding at a time.
//
// Optional feature: define PQ_ARB_STATS_EN to add saturating 32-bit
// completion counters (stat_enq, stat_deq, stat_err).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/op/kv       per-client request (op 0 = enqueue, 1 = dequeue)
//   req_ready             one-hot accept strobe, combinational, IDLE only
//   rsp_valid/id/kv/err   one-cycle completion pulse and its payload
//   pq_enq/pq_deq/pq_kvi  command pulses and enqueue data to the queue
//   pq_kvo/busy/full/empty queue head and status from the queue
//   stat_enq/deq/err      completion counters (PQ_ARB_STATS_EN only)

package pq_pkg;
  localparam int unsigned KEY_W = 8;
  localparam int unsigned VAL_W = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  localparam logic [KEY_W-1:0] KEYINF   = '1;
  localparam kv_t              KV_EMPTY = '{key: KEYINF, val: '0};
endpackage

module pq_arbiter
  import pq_pkg::*;
#(
  parameter int unsigned N_CLIENTS = 4,
  parameter int unsigned ID_W      = $clog2(N_CLIENTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CLIENTS-1:0]  req_valid,
  input  logic [N_CLIENTS-1:0]  req_op,
  input  kv_t  [N_CLIENTS-1:0]  req_kv,
  output logic [N_CLIENTS-1:0]  req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output kv_t                   rsp_kv,
  output logic                  rsp_err,
  output logic                  pq_enq,
  output logic                  pq_deq,
  output kv_t                   pq_kvi,
  input  kv_t                   pq_kvo,
  input  logic                  pq_busy,
  input  logic                  pq_full,
  input  logic                  pq_empty
`ifdef PQ_ARB_STATS_EN
  ,
  output logic [31:0]           stat_enq,
  output logic [31:0]           stat_deq,
  output logic [31:0]           stat_err
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            op_q, op_d;
  kv_t             kv_q, kv_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  kv_t             rsp_kv_q, rsp_kv_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;

  // Round-robin search starting one past the last winner, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_CLIENTS; i++) begin
      cand = ID_W'((32'(rr_ptr_q) + i) % N_CLIENTS);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Next-state and command/strobe logic.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    op_d      = op_q;
    kv_d      = kv_q;
    rsp_id_d  = rsp_id_q;
    rsp_kv_d  = rsp_kv_q;
    rsp_err_d = rsp_err_q;
    req_ready = '0;
    pq_enq    = 1'b0;
    pq_deq    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          // Strobe is masked during reset so nothing looks accepted.
          req_ready[gnt_idx] = ~rst;
          rr_ptr_d  = gnt_idx;
          op_d      = req_op[gnt_idx];
          kv_d      = req_kv[gnt_idx];
          rsp_id_d  = gnt_idx;
          rsp_kv_d  = KV_EMPTY;
          rsp_err_d = 1'b0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // Status flags are only trusted once the queue is idle.
        if (!pq_busy) begin
          if (op_q ? pq_empty : pq_full) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            pq_enq  = ~op_q;
            pq_deq  = op_q;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!pq_busy) begin
          if (op_q) rsp_kv_d = pq_kvo;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rsp_valid_d = (state_d == RESP);
  end

  // State and payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(N_CLIENTS - 1);
      op_q        <= 1'b0;
      kv_q        <= KV_EMPTY;
      rsp_id_q    <= '0;
      rsp_kv_q    <= KV_EMPTY;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      kv_q        <= kv_d;
      rsp_id_q    <= rsp_id_d;
      rsp_kv_q    <= rsp_kv_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign pq_kvi    = kv_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_kv    = rsp_kv_q;
  assign rsp_err   = rsp_err_q;

`ifdef PQ_ARB_STATS_EN
  localparam int unsigned STAT_W = 32;

  logic [STAT_W-1:0] stat_enq_q, stat_deq_q, stat_err_q;

  // Saturating completion counters, bumped once per response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_enq_q <= '0;
      stat_deq_q <= '0;
      stat_err_q <= '0;
    end else if (state_q == RESP) begin
      if (rsp_err_q) begin
        if (stat_err_q != '1) stat_err_q <= stat_err_q + STAT_W'(1);
      end else if (op_q) begin
        if (stat_deq_q != '1) stat_deq_q <= stat_deq_q + STAT_W'(1);
      end else begin
        if (stat_enq_q != '1) stat_enq_q <= stat_enq_q + STAT_W'(1);
      end
    end
  end

  assign stat_enq = stat_enq_q;
  assign stat_deq = stat_deq_q;
  assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_pq_arbiter.sv
// Directed bench for pq_arbiter: expected responses are queued when a grant
// is seen and a negedge monitor pops and compares each rsp_valid pulse.
module tb_pq_arbiter;
  import pq_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned ID_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_op;
  kv_t  [N-1:0]      req_kv;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  kv_t               rsp_kv;
  logic              rsp_err;
  logic              pq_enq;
  logic              pq_deq;
  kv_t               pq_kvi;
  kv_t               pq_kvo;
  logic              pq_busy;
  logic              pq_full;
  logic              pq_empty;
`ifdef PQ_ARB_STATS_EN
  logic [31:0]       stat_enq, stat_deq, stat_err;
`endif

  pq_arbiter #(.N_CLIENTS(N), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_kv(req_kv),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_kv(rsp_kv), .rsp_err(rsp_err),
    .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi),
    .pq_kvo(pq_kvo), .pq_busy(pq_busy), .pq_full(pq_full), .pq_empty(pq_empty)
`ifdef PQ_ARB_STATS_EN
    , .stat_enq(stat_enq), .stat_deq(stat_deq), .stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0] id;
    kv_t             kv;
    logic            err;
    logic [31:0]     cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic kv_t mk(input logic [7:0] k, input logic [7:0] v);
    kv_t r;
    r.key = k;
    r.val = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: command exclusivity every cycle, scoreboard pop on each response.
  always @(negedge clk) begin
    chk("enq_deq_excl", 32'(pq_enq & pq_deq), 32'd0);
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id %0d expected no response (cycle %0d)", rsp_id, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id",    32'(rsp_id),  32'(mon_e.id));
        chk("rsp_kv",    32'(rsp_kv),  32'(mon_e.kv));
        chk("rsp_err",   32'(rsp_err), 32'(mon_e.err));
        chk("rsp_cycle", 32'(cyc),     mon_e.cyc);
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_pq_enq",    32'(pq_enq),    32'd0);
    chk("rst_pq_deq",    32'(pq_deq),    32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_kv",    32'(rsp_kv),    32'(KV_EMPTY));
    chk("rst_pq_kvi",    32'(pq_kvi),    32'(KV_EMPTY));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '1;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = '0;
  endtask

  // Wait (bounded) for a grant, check it, optionally queue the expected response.
  task automatic grant_one(input logic [N-1:0] exp_rdy, input int exp_id, input bit push,
                           input int lat, input kv_t ekv, input bit eerr);
    bit got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (|req_ready) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL grant_timeout: got no req_ready expected %b", exp_rdy);
    end else begin
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (push) sb.push_back('{id: ID_W'(exp_id), kv: ekv, err: eerr, cyc: 32'(cyc + lat)});
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rsp_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_kv    = {N{KV_EMPTY}};
    pq_kvo    = KV_EMPTY;
    pq_busy   = 1'b0;
    pq_full   = 1'b0;
    pq_empty  = 1'b0;

    // Reset values, then client 2 enqueues key 5.
    do_reset();
    req_valid[2] = 1'b1;
    req_op[2]    = 1'b0;
    req_kv[2]    = mk(8'd5, 8'h11);
    grant_one(4'b0100, 2, 1'b1, 3, KV_EMPTY, 1'b0);
    req_valid = 4'b1011;
    @(negedge clk);
    chk("enq_pulse",     32'(pq_enq),    32'd1);
    chk("enq_kvi",       32'(pq_kvi),    32'(mk(8'd5, 8'h11)));
    chk("enq_no_deq",    32'(pq_deq),    32'd0);
    chk("ready_busy_t1", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("enq_one_cycle", 32'(pq_enq),    32'd0);
    chk("ready_busy_t2", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_done();

    // Round-robin with all clients requesting continuously.
    do_reset();
    req_op = '0;
    for (int i = 0; i < N; i++) req_kv[i] = mk(8'(i + 1), 8'h00);
    req_valid = '1;
    grant_one(4'b0001, 0, 1'b1, 3, KV_EMPTY, 1'b0);
    grant_one(4'b0010, 1, 1'b1, 3, KV_EMPTY, 1'b0);
    grant_one(4'b0100, 2, 1'b1, 3, KV_EMPTY, 1'b0);
    grant_one(4'b1000, 3, 1'b1, 3, KV_EMPTY, 1'b0);
    grant_one(4'b0001, 0, 1'b1, 3, KV_EMPTY, 1'b0);
    req_valid = '0;
    wait_done();

    // Client 1 dequeue from an empty queue.
    pq_empty     = 1'b1;
    req_valid[1] = 1'b1;
    req_op[1]    = 1'b1;
    grant_one(4'b0010, 1, 1'b1, 2, KV_EMPTY, 1'b1);
    req_valid = '0;
    @(negedge clk);
    chk("empty_no_deq", 32'(pq_deq), 32'd0);
    @(posedge clk); #1;
    pq_empty = 1'b0;
    wait_done();

    // Client 3 enqueue into a full queue.
    pq_full      = 1'b1;
    req_valid[3] = 1'b1;
    req_op[3]    = 1'b0;
    req_kv[3]    = mk(8'd9, 8'h99);
    grant_one(4'b1000, 3, 1'b1, 2, KV_EMPTY, 1'b1);
    req_valid = '0;
    @(negedge clk);
    chk("full_no_enq", 32'(pq_enq), 32'd0);
    @(posedge clk); #1;
    pq_full = 1'b0;
    wait_done();

    // Client 0 dequeue; queue busy three cycles, head captured on first idle cycle.
    pq_kvo       = mk(8'h20, 8'h01);
    req_valid[0] = 1'b1;
    req_op[0]    = 1'b1;
    grant_one(4'b0001, 0, 1'b1, 6, mk(8'h03, 8'h44), 1'b0);
    req_valid = '0;
    @(negedge clk);
    chk("deq_pulse",  32'(pq_deq), 32'd1);
    chk("deq_no_enq", 32'(pq_enq), 32'd0);
    @(posedge clk); #1;
    pq_busy = 1'b1;
    pq_kvo  = mk(8'h77, 8'h77);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pq_busy = 1'b0;
    pq_kvo  = mk(8'h03, 8'h44);
    @(posedge clk); #1;
    pq_kvo  = mk(8'h88, 8'h88);
    wait_done();

    // Client 1 enqueue stalls in ISSUE while the queue is busy.
    req_valid[1] = 1'b1;
    req_op[1]    = 1'b0;
    req_kv[1]    = mk(8'h42, 8'h24);
    grant_one(4'b0010, 1, 1'b1, 5, KV_EMPTY, 1'b0);
    req_valid = '0;
    pq_busy   = 1'b1;
    @(negedge clk);
    chk("stall_no_enq_a", 32'(pq_enq), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_no_enq_b", 32'(pq_enq), 32'd0);
    @(posedge clk); #1;
    pq_busy = 1'b0;
    @(negedge clk);
    chk("stall_enq_pulse", 32'(pq_enq), 32'd1);
    chk("stall_enq_kvi",   32'(pq_kvi), 32'(mk(8'h42, 8'h24)));
    @(posedge clk); #1;
    wait_done();

    // Reset while in WAIT: request abandoned, client 0 granted first after.
    req_valid[2] = 1'b1;
    req_op[2]    = 1'b0;
    grant_one(4'b0100, 2, 1'b0, 0, KV_EMPTY, 1'b0);
    req_valid = '0;
    @(negedge clk);
    chk("wait_enq_pulse", 32'(pq_enq), 32'd1);
    @(posedge clk); #1;
    pq_busy   = 1'b1;
    rst       = 1'b1;
    req_valid = '1;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst     = 1'b0;
    pq_busy = 1'b0;
    req_op  = '0;
    grant_one(4'b0001, 0, 1'b1, 3, KV_EMPTY, 1'b0);
    req_valid = '0;
    wait_done();

`ifdef PQ_ARB_STATS_EN
    // Counters: two enqueues, one dequeue, one empty-error dequeue.
    do_reset();
    req_op = '0;
    req_valid[0] = 1'b1;
    grant_one(4'b0001, 0, 1'b1, 3, KV_EMPTY, 1'b0);
    req_valid = '0;
    wait_done();
    req_valid[1] = 1'b1;
    grant_one(4'b0010, 1, 1'b1, 3, KV_EMPTY, 1'b0);
    req_valid = '0;
    wait_done();
    pq_kvo       = mk(8'h10, 8'h20);
    req_valid[2] = 1'b1;
    req_op[2]    = 1'b1;
    grant_one(4'b0100, 2, 1'b1, 3, mk(8'h10, 8'h20), 1'b0);
    req_valid = '0;
    wait_done();
    pq_empty     = 1'b1;
    req_valid[3] = 1'b1;
    req_op[3]    = 1'b1;
    grant_one(4'b1000, 3, 1'b1, 2, KV_EMPTY, 1'b1);
    req_valid = '0;
    wait_done();
    pq_empty = 1'b0;
    chk("stat_enq", stat_enq, 32'd2);
    chk("stat_deq", stat_deq, 32'd1);
    chk("stat_err", stat_err, 32'd1);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
